// File: rtl/gray_counter_ud.sv
// Up/down Gray-code counter with enable, synchronous clear/load, wrap-or-saturate
// mode and a registered wrap pulse. Both the Gray and binary outputs come straight from flops.
module gray_counter_ud #(
  parameter int          WIDTH    = 4,
  parameter int          SATURATE = 0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RST_VAL);
  localparam bit               SAT     = (SATURATE != 0);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;

  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (clr) begin
      bin_nxt = ZERO;
    end else if (load) begin
      bin_nxt = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (bin_q == MAX) begin
          if (!SAT) begin
            bin_nxt  = ZERO;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_q + ONE;
        end
      end else begin
        if (bin_q == ZERO) begin
          if (!SAT) begin
            bin_nxt  = MAX;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_q - ONE;
        end
      end
    end
  end

  // Gray is encoded from the next binary value so both outputs update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RST_BIN;
      gray_q <= to_gray(RST_BIN);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= to_gray(bin_nxt);
      wrap_q <= wrap_nxt;
    end
  end

  assign gray     = gray_q;
  assign bin      = bin_q;
  assign wrap     = wrap_q;
  assign at_limit = up_dn ? (bin_q == MAX) : (bin_q == ZERO);

endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: four configurations share one stimulus stream and are
// compared each cycle against an integer reference model, plus directed tables.
module tb_gray_counter_ud;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, clr, load;
  logic [7:0] load_val;

  logic [3:0] g4, b4, g4s, b4s;
  logic [1:0] g2, b2;
  logic [7:0] g8, b8;
  logic       w4, l4, w4s, l4s, w2, l2, w8, l8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gray_counter_ud #(.WIDTH(4), .SATURATE(0), .RST_VAL(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .gray(g4), .bin(b4), .wrap(w4), .at_limit(l4));
  gray_counter_ud #(.WIDTH(4), .SATURATE(1), .RST_VAL(6)) u4s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .gray(g4s), .bin(b4s), .wrap(w4s), .at_limit(l4s));
  gray_counter_ud #(.WIDTH(2), .SATURATE(0), .RST_VAL(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[1:0]), .gray(g2), .bin(b2), .wrap(w2), .at_limit(l2));
  gray_counter_ud #(.WIDTH(8), .SATURATE(0), .RST_VAL(0)) u8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .gray(g8), .bin(b8), .wrap(w8), .at_limit(l8));

  // Reference model: one integer count per instance.
  int          mw  [4] = '{4, 4, 2, 8};
  int          msat[4] = '{0, 1, 0, 0};
  int unsigned mrv [4] = '{0, 6, 0, 0};
  int unsigned mbin[4];
  int unsigned mwrap[4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mbin[i]  = mrv[i];
      mwrap[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int unsigned period = 1 << mw[i];
      mwrap[i] = 0;
      if (rst) begin
        mbin[i] = mrv[i];
      end else if (clr) begin
        mbin[i] = 0;
      end else if (load) begin
        mbin[i] = load_val % period;
      end else if (en) begin
        int unsigned target = up_dn ? (mbin[i] + 1) % period : (mbin[i] + period - 1) % period;
        bit crosses = up_dn ? (mbin[i] == period - 1) : (mbin[i] == 0);
        if (!(crosses && msat[i] != 0)) begin
          mbin[i]  = target;
          mwrap[i] = crosses;
        end
      end
    end
  endtask

  task automatic get(input int i, output logic [31:0] g, output logic [31:0] b,
                     output logic w, output logic l);
    case (i)
      0:       begin g = 32'(g4);  b = 32'(b4);  w = w4;  l = l4;  end
      1:       begin g = 32'(g4s); b = 32'(b4s); w = w4s; l = l4s; end
      2:       begin g = 32'(g2);  b = 32'(b2);  w = w2;  l = l2;  end
      default: begin g = 32'(g8);  b = 32'(b8);  w = w8;  l = l8;  end
    endcase
  endtask

  task automatic chk(input string name, input int i, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, i, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] g, b;
    logic w, l;
    for (int i = 0; i < 4; i++) begin
      int unsigned top = (1 << mw[i]) - 1;
      get(i, g, b, w, l);
      chk("model_bin", i, b, mbin[i]);
      chk("model_gray", i, g, mbin[i] ^ (mbin[i] >> 1));
      chk("model_wrap", i, 32'(w), mwrap[i]);
      chk("model_limit", i, 32'(l), up_dn ? 32'(mbin[i] == top) : 32'(mbin[i] == 0));
    end
  endtask

  task automatic step();
    logic [31:0] pg[4];
    int unsigned old[4];
    logic [31:0] g, b;
    logic w, l;
    bit plain;
    for (int i = 0; i < 4; i++) begin
      get(i, g, b, w, l);
      pg[i]  = g;
      old[i] = mbin[i];
    end
    plain = !rst && !clr && !load && en;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (plain) begin
      for (int i = 0; i < 4; i++) begin
        if (mbin[i] != old[i]) begin
          get(i, g, b, w, l);
          chk("hamming1", i, 32'($countones(g ^ pg[i])), 32'd1);
        end
      end
    end
  endtask

  typedef struct {
    logic       clr, load, en, up;
    logic [7:0] lv;
    int         b, g, w, l;
  } vec_t;

  vec_t tbl[16];
  int   seq[20] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0, 1, 3, 2};
  int   wraps2, wraps8;

  initial begin
    // Expectations for the WIDTH=4 wrapping instance.
    tbl[0]  = '{0, 1, 0, 0, 8'h2, 2,  3,  0, 0};
    tbl[1]  = '{0, 0, 1, 0, 8'h0, 1,  1,  0, 0};
    tbl[2]  = '{0, 0, 1, 0, 8'h0, 0,  0,  0, 1};
    tbl[3]  = '{0, 0, 1, 0, 8'h0, 15, 8,  1, 0};
    tbl[4]  = '{0, 0, 1, 0, 8'h0, 14, 9,  0, 0};
    tbl[5]  = '{0, 1, 1, 1, 8'h5, 5,  7,  0, 0};
    tbl[6]  = '{1, 1, 1, 1, 8'hA, 0,  0,  0, 0};
    tbl[7]  = '{0, 1, 1, 1, 8'hA, 10, 15, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 8'h0, 10, 15, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 8'h0, 10, 15, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 8'h0, 10, 15, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 8'hF, 15, 8,  0, 1};
    tbl[12] = '{0, 0, 1, 1, 8'h0, 0,  0,  1, 0};
    tbl[13] = '{0, 0, 1, 0, 8'h0, 15, 8,  1, 0};
    tbl[14] = '{0, 0, 1, 1, 8'h0, 0,  0,  1, 0};
    tbl[15] = '{1, 0, 0, 1, 8'h0, 0,  0,  0, 0};

    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h0;
    model_reset();
    #2;
    check_all();
    chk("rst_bin_sat", 1, 32'(b4s), 32'd6);
    chk("rst_gray_sat", 1, 32'(g4s), 32'd5);
    @(negedge clk);
    rst = 1'b0;

    en = 1'b1; up_dn = 1'b1;
    chk("seq_gray", 0, 32'(g4), seq[0]);
    for (int k = 1; k < 20; k++) begin
      step();
      chk("seq_gray", 0, 32'(g4), seq[k]);
      chk("seq_wrap", 0, 32'(w4), (k == 16) ? 1 : 0);
    end

    for (int v = 0; v < 16; v++) begin
      clr = tbl[v].clr; load = tbl[v].load; en = tbl[v].en;
      up_dn = tbl[v].up; load_val = tbl[v].lv;
      step();
      chk("tbl_bin", v, 32'(b4), tbl[v].b);
      chk("tbl_gray", v, 32'(g4), tbl[v].g);
      chk("tbl_wrap", v, 32'(w4), tbl[v].w);
      chk("tbl_limit", v, 32'(l4), tbl[v].l);
    end

    clr = 1'b0; load = 1'b1; load_val = 8'hE; en = 1'b0; up_dn = 1'b1;
    step();
    chk("sat_load", 1, 32'(b4s), 32'hE);
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sat_bin", 1, 32'(b4s), 32'hF);
      chk("sat_wrap", 1, 32'(w4s), 32'd0);
      chk("sat_limit", 1, 32'(l4s), 32'd1);
    end
    up_dn = 1'b0;
    #1;
    chk("sat_limit_drop", 1, 32'(l4s), 32'd0);
    step();
    chk("sat_down", 1, 32'(b4s), 32'hE);

    load = 1'b1; load_val = 8'h8; en = 1'b0; up_dn = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk("pre_rst_bin", 1, 32'(b4s), 32'h9);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_bin", 1, 32'(b4s), 32'h6);
    chk("async_gray", 1, 32'(g4s), 32'h5);
    chk("async_wrap", 1, 32'(w4s), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_bin", 1, 32'(b4s), 32'h7);
    step();
    chk("post_rst_bin", 1, 32'(b4s), 32'h8);

    for (int dir = 1; dir >= 0; dir--) begin
      clr = 1'b1; en = 1'b0;
      step();
      clr = 1'b0; en = 1'b1; up_dn = dir[0];
      wraps2 = 0; wraps8 = 0;
      for (int k = 0; k < 256; k++) begin
        step();
        wraps2 += int'(w2);
        wraps8 += int'(w8);
      end
      chk("period_bin8", 3, 32'(b8), 32'd0);
      chk("period_bin2", 2, 32'(b2), 32'd0);
      chk("wraps8", 3, wraps8, 32'd1);
      chk("wraps2", 2, wraps2, 32'd64);
    end

    for (int k = 0; k < 400; k++) begin
      clr      = ($urandom % 20) == 0;
      load     = ($urandom % 10) == 0;
      en       = ($urandom % 4) != 0;
      up_dn    = $urandom % 2;
      load_val = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_counter_ud.md
# gray_counter_ud

Parametrised Gray-code counter. It keeps an internal binary count and drives a registered, glitch-free Gray output plus a registered binary mirror. It adds what the fixed 4-bit free-running counter lacks: up/down direction, count enable, synchronous clear and load, a wrap-or-saturate mode, and a wrap pulse. It is the standard pointer/sequence source for clock-domain-crossing FIFOs and rotary position logic.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limits.
- RST_VAL, 0, binary value loaded on reset; must be < 2^WIDTH.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; one step per enabled cycle.
- up_dn  in  1  1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to binary 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  binary value to load.
- gray  out  WIDTH  registered Gray code of the count.
- bin  out  WIDTH  registered binary count.
- wrap  out  1  registered one-cycle pulse on a wrap step.
- at_limit  out  1  combinational; count is at the terminal value for the current up_dn.

## Operation
- The state is bin_q (WIDTH bits), gray_q and wrap_q.
- gray_q always equals bin_q ^ (bin_q >> 1). It is computed from the next binary value and registered on the same edge, so the output never carries combinational logic.
- Per edge, the priority is: clr > load > en > hold.
  - clr: bin_q <= 0; wrap_q <= 0.
  - load: bin_q <= load_val; wrap_q <= 0.
  - en, up_dn = 1:
    - If bin_q == 2^WIDTH-1 and SATURATE = 0: bin_q <= 0, wrap_q <= 1.
    - If bin_q == 2^WIDTH-1 and SATURATE = 1: bin_q holds, wrap_q <= 0.
    - Otherwise: bin_q + 1, wrap_q <= 0.
  - en, up_dn = 0:
    - If bin_q == 0 and SATURATE = 0: bin_q <= 2^WIDTH-1, wrap_q <= 1.
    - If bin_q == 0 and SATURATE = 1: bin_q holds, wrap_q <= 0.
    - Otherwise: bin_q - 1, wrap_q <= 0.
  - no enable: bin_q holds; wrap_q <= 0.
- Arithmetic is modulo 2^WIDTH. No carry or borrow is exposed beyond wrap.
- at_limit = up_dn ? (bin_q == all-ones) : (bin_q == 0). It follows up_dn combinationally and does not depend on en.
- Every enabled non-saturated step changes exactly one gray bit. Wrap steps also change exactly one bit (Gray code is cyclic). clr and load may change several bits.
- Direction may change on any cycle. The step taken is the one selected by up_dn in that cycle, with no dead cycle.

## Timing
- Reset (async assert, any time): bin = RST_VAL and gray = RST_VAL ^ (RST_VAL >> 1) immediately; wrap = 0. at_limit reflects the reset value.
- Reset release is synchronous to clk. The first step can occur on the first rising edge at which rst is low and en is high.
- Latency: a control input sampled on edge k appears on gray, bin and wrap after edge k. This is one cycle, with no pipeline.
- wrap is high for exactly the one cycle following the wrapping edge. Back-to-back wraps (for example, WIDTH = 2 toggling direction at the boundaries) produce a pulse on each such edge.
- Simultaneous inputs: clr with load gives 0. load with en gives load_val, with no step applied. clr with en gives 0.
- Reset asserted mid-count overrides everything asynchronously. No partial step is visible.
- Saturated hold with en = 1: outputs stay stable, wrap = 0, at_limit = 1.

## Test plan
- Reset and free count up: WIDTH = 4, RST_VAL = 0, en = 1, up_dn = 1 for 20 cycles.
  - gray sequence is 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1,3,2.
  - wrap pulses only on the cycle where gray goes 8->0.
  - Every transition has Hamming distance 1.
- Count down across zero: load 2, then up_dn = 0, en = 1.
  - bin goes 2,1,0,F,E.
  - gray goes 3,1,0,8,9.
  - wrap is high only in the F cycle.
- Saturate mode: SATURATE = 1, load E, count up 4 cycles.
  - bin goes E,F,F,F.
  - wrap stays 0.
  - at_limit = 1 from the first F cycle.
  - Then up_dn = 0: at_limit drops and bin becomes E on the next edge.
- Priority and holds:
  - From bin = 5, assert clr, load (load_val = A) and en together: bin = 0.
  - Next cycle, load with en: bin = A.
  - en = 0 for 3 cycles: bin stays A and gray stays F.
- Asynchronous reset mid-count: RST_VAL = 6, count to 9, assert rst between edges.
  - bin = 6 and gray = 5 before the next edge; wrap = 0.
  - After release with en = 1, bin goes 7,8,...
- Width sweep: WIDTH = 2 and WIDTH = 8, full up and down cycles.
  - Period is 2^WIDTH.
  - Exactly one wrap per period.
  - gray always equals bin ^ (bin >> 1).
